convolution_with_mem: RTL and testbench
=======================================

CONVOLUTION_WITH_MEM -- requirements
Module: convolution_with_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, bus data width.
REQ-003 SHALL have parameter N, default 4, input matrix dimension (N x N).
REQ-004 SHALL have parameter K, default 2, kernel dimension (K x K); output dimension is N-K+1 = 3.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, request to begin a convolution.
REQ-008 SHALL have port done, output, 1, convolution complete; bus released.
REQ-009 SHALL have ports matrix_addr, kernel_addr and output_addr, input, ADDR_W each, base addresses of the matrix, kernel and result regions.
REQ-010 SHALL have port mem_w, output, 1, memory write enable.
REQ-011 SHALL have port mem_sel, output, 1, memory select.
REQ-012 SHALL have port address_bus, inout, ADDR_W, shared address bus.
REQ-013 SHALL have port data_bus, inout, DATA_W, shared data bus.

Function
REQ-014 SHALL store matrix elements row-major at matrix_addr+i, kernel elements row-major at kernel_addr+i, and results row-major at output_addr+3*r+c; all address sums wrap modulo 256.
REQ-015 SHALL treat each operand as signed 8-bit taken from data_bus[7:0].
REQ-016 SHALL compute out[r][c] = sum over (a,b) in 0..1 of m[r+a][c+b]*k[a][b], with 32-bit signed accumulation, written sign-extended to DATA_W.
REQ-017 SHALL implement the states IDLE, READ_K, READ_M, WRITE and DONE.
REQ-018 SHALL move from IDLE or DONE to READ_K when start=1 is sampled on a rising edge; start SHALL be ignored in all other states.
REQ-019 SHALL, in READ_K, drive mem_sel=1, mem_w=0 and address kernel_addr+idx, capturing data_bus into k[idx] on each edge; after 4 words it SHALL move to READ_M.
REQ-020 SHALL, in READ_M, read 16 words the same way into m[0..15] (one per cycle), then move to WRITE.
REQ-021 SHALL, in WRITE, drive mem_sel=1, mem_w=1, the address output_addr+idx and the data out[idx] for idx 0..8, one word per cycle, then move to DONE.
REQ-022 SHALL, in DONE, hold done=1 and clear done when start is accepted.
REQ-023 SHALL make done rise 29 rising edges after the edge that sampled start: 4 reads + 16 reads + 9 writes.
REQ-024 SHALL tri-state address_bus in IDLE and DONE, and SHALL drive mem_sel=0 and mem_w=0 in those states.
REQ-025 SHALL drive data_bus only in WRITE and tri-state it otherwise.
REQ-026 (mem sub-block) SHALL provide 256 x 32-bit words with ports clk, w_en, sel, address_bus (input), data_bus (inout).
REQ-027 (mem sub-block) SHALL perform a synchronous write on a rising edge when sel=1 and w_en=1.
REQ-028 (mem sub-block) SHALL perform a combinational read, driving data_bus when sel=1 and w_en=0, and SHALL tri-state data_bus otherwise.
REQ-029 (mem sub-block) SHALL leave memory contents uninitialized.

Reset
REQ-030 SHALL, with rst=0 at any time (including mid-operation), go to IDLE asynchronously with done=0, mem_sel=0, mem_w=0, both buses tri-stated, indices cleared, and no further memory writes.
REQ-031 SHALL not clear previously written memory contents on reset.

Structure
REQ-032 SHALL place ADDR_W, DATA_W, N, K, the output size 3 and the state encoding in a shared package conv_pkg.
REQ-033 SHALL have mem as the single sub-module; convolution_with_mem shares the bus with external masters and does not instantiate mem.
REQ-034 SHALL keep kernel and matrix operands in internal register arrays, with MAC logic combinational per output index.

Verification
REQ-035 Load matrix 1..16 at 0 and kernel {1,0,0,-1} at 16, output_addr=20, pulse start -> addresses 20..28 each read -5 (0xFFFFFFFB); done asserted 29 edges after start.
REQ-036 Kernel {1,1,1,1} with the same matrix -> outputs 14,18,22,30,34,38,46,50,54.
REQ-037 Matrix all -128, kernel all -128 -> each output 65536.
REQ-038 Assert rst=0 mid-READ_M -> done=0, buses Z immediately; output region unchanged; a later start completes correctly.
REQ-039 matrix_addr=250 (wraps past 255) -> correct results; start pulsed while busy -> ignored, same 29-edge latency.
REQ-040 In IDLE and DONE -> address_bus and data_bus are Z and an external master can write to and read from mem.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared sizing constants and controller state encoding for the convolution engine.
package conv_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int N       = 4;
  localparam int K       = 2;
  localparam int OUT_DIM = N - K + 1;

  typedef enum logic [2:0] {
    StIdle,
    StReadK,
    StReadM,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/mem.sv
// 256-word shared-bus memory: synchronous write, combinational read onto data_bus.
module mem #(
  parameter int ADDR_W = conv_pkg::ADDR_W,
  parameter int DATA_W = conv_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              w_en,
  input  logic              sel,
  input  logic [ADDR_W-1:0] address_bus,
  inout  wire  [DATA_W-1:0] data_bus
);

  logic [DATA_W-1:0] ram [2**ADDR_W];

  // Store the bus word when selected for writing; contents are never initialised.
  always_ff @(posedge clk) begin
    if (sel && w_en) ram[address_bus] <= data_bus;
  end

  assign data_bus = (sel && !w_en) ? ram[address_bus] : {DATA_W{1'bz}};

endmodule

// File: rtl/convolution_with_mem.sv
// Bus-master convolution engine: fetches kernel and matrix from shared memory,
// then writes the valid-region 2-D convolution back one word per cycle.
module convolution_with_mem #(
  parameter int ADDR_W = conv_pkg::ADDR_W,
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int N      = conv_pkg::N,
  parameter int K      = conv_pkg::K
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  input  logic [ADDR_W-1:0] matrix_addr,
  input  logic [ADDR_W-1:0] kernel_addr,
  input  logic [ADDR_W-1:0] output_addr,
  output logic              mem_w,
  output logic              mem_sel,
  inout  wire  [ADDR_W-1:0] address_bus,
  inout  wire  [DATA_W-1:0] data_bus
);
  import conv_pkg::*;

  localparam int KLen   = K * K;
  localparam int MLen   = N * N;
  localparam int OutDim = N - K + 1;
  localparam int OLen   = OutDim * OutDim;
  localparam int IdxW   = $clog2(MLen + 1);
  localparam int KIdxW  = $clog2(KLen);
  localparam int MIdxW  = $clog2(MLen);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic signed [7:0] k_q [KLen];
  logic signed [7:0] m_q [MLen];
  logic [ADDR_W-1:0] addr;
  logic signed [31:0] acc;
  logic              unused_data_hi;

  assign unused_data_hi = ^data_bus[DATA_W-1:8];

  // Controller state and word index; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: a fixed-length burst of kernel reads, matrix reads, then result writes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StReadK;
          idx_d   = '0;
        end
      end
      StReadK: begin
        if (idx_q == IdxW'(KLen - 1)) begin
          state_d = StReadM;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StReadM: begin
        if (idx_q == IdxW'(MLen - 1)) begin
          state_d = StWrite;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StWrite: begin
        if (idx_q == IdxW'(OLen - 1)) begin
          state_d = StDone;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  // Operand capture from the memory's combinational read data.
  always_ff @(posedge clk) begin
    if (state_q == StReadK) k_q[idx_q[KIdxW-1:0]] <= $signed(data_bus[7:0]);
    if (state_q == StReadM) m_q[idx_q[MIdxW-1:0]] <= $signed(data_bus[7:0]);
  end

  // Bus control and address generation; the bus is released outside the burst.
  always_comb begin
    done    = (state_q == StDone);
    mem_sel = 1'b0;
    mem_w   = 1'b0;
    addr    = '0;
    unique case (state_q)
      StReadK: begin
        mem_sel = 1'b1;
        addr    = kernel_addr + ADDR_W'(idx_q);
      end
      StReadM: begin
        mem_sel = 1'b1;
        addr    = matrix_addr + ADDR_W'(idx_q);
      end
      StWrite: begin
        mem_sel = 1'b1;
        mem_w   = 1'b1;
        addr    = output_addr + ADDR_W'(idx_q);
      end
      default: ;
    endcase
  end

  // MAC for the output element currently being written (row-major index idx_q).
  always_comb begin
    int r;
    int c;
    r   = int'(idx_q) / OutDim;
    c   = int'(idx_q) % OutDim;
    acc = '0;
    for (int a = 0; a < K; a++) begin
      for (int b = 0; b < K; b++) begin
        acc = acc + 32'(m_q[MIdxW'((r + a) * N + c + b)]) * 32'(k_q[KIdxW'(a * K + b)]);
      end
    end
  end

  assign address_bus = mem_sel ? addr : {ADDR_W{1'bz}};
  assign data_bus    = mem_w ? DATA_W'(acc) : {DATA_W{1'bz}};

endmodule

// File: tb/tb_convolution_with_mem.sv
// Directed + randomized bench: an external master loads memory, the engine convolves,
// results are read back and compared with an arithmetic reference model.
module tb_convolution_with_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [7:0]  matrix_addr = '0, kernel_addr = '0, output_addr = '0;
  logic        dut_w, dut_sel;
  wire  [7:0]  address_bus;
  wire  [31:0] data_bus;

  logic        ext_sel = 1'b0, ext_w = 1'b0, ext_addr_en = 1'b0, ext_data_en = 1'b0;
  logic [7:0]  ext_addr = '0;
  logic [31:0] ext_data = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mat_w [16];
  logic [31:0] ker_w [4];

  assign address_bus = ext_addr_en ? ext_addr : 8'bz;
  assign data_bus    = ext_data_en ? ext_data : 32'bz;

  always #5 clk = ~clk;

  convolution_with_mem dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .matrix_addr(matrix_addr), .kernel_addr(kernel_addr), .output_addr(output_addr),
    .mem_w(dut_w), .mem_sel(dut_sel), .address_bus(address_bus), .data_bus(data_bus)
  );

  mem u_mem (
    .clk(clk), .w_en(dut_w | ext_w), .sel(dut_sel | ext_sel),
    .address_bus(address_bus), .data_bus(data_bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ext_write(input logic [7:0] a, input logic [31:0] d);
    ext_addr = a; ext_data = d;
    ext_addr_en = 1'b1; ext_data_en = 1'b1; ext_sel = 1'b1; ext_w = 1'b1;
    @(posedge clk);
    #1;
    ext_addr_en = 1'b0; ext_data_en = 1'b0; ext_sel = 1'b0; ext_w = 1'b0;
  endtask

  task automatic ext_read(input logic [7:0] a, output logic [31:0] d);
    ext_addr = a; ext_addr_en = 1'b1; ext_sel = 1'b1; ext_w = 1'b0;
    #1;
    d = data_bus;
    ext_addr_en = 1'b0; ext_sel = 1'b0;
    #1;
  endtask

  // Reference: valid 2x2 convolution of signed low bytes, plain integer arithmetic.
  function automatic logic [31:0] model(input int r, input int c);
    int s = 0;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        s += int'($signed(mat_w[(r + a) * 4 + c + b][7:0]))
           * int'($signed(ker_w[a * 2 + b][7:0]));
    return 32'(s);
  endfunction

  task automatic load(input logic [7:0] ma, input logic [7:0] ka);
    for (int i = 0; i < 16; i++) ext_write(ma + 8'(i), mat_w[i]);
    for (int i = 0; i < 4; i++) ext_write(ka + 8'(i), ker_w[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Runs one convolution and checks latency, first bus address and every result.
  task automatic run_conv(input string tag, input logic [7:0] ma, input logic [7:0] ka,
                          input logic [7:0] oa, input bit busy_start);
    int cnt;
    logic [31:0] d;
    matrix_addr = ma; kernel_addr = ka; output_addr = oa;
    pulse_start();
    chk({tag, "_addr0"}, {24'd0, address_bus}, {24'd0, ka});
    chk({tag, "_busy_done"}, {31'd0, done}, 32'd0);
    cnt = 0;
    while (!done && cnt < 100) begin
      if (busy_start && cnt == 10) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'd29);
    for (int i = 0; i < 9; i++) begin
      ext_read(oa + 8'(i), d);
      chk($sformatf("%s_out%0d", tag, i), d, model(i / 3, i % 3));
    end
    chk({tag, "_done_hold"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  base;

    // Reset state
    #12;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sel", {31'd0, dut_sel}, 32'd0);
    chk("rst_w", {31'd0, dut_w}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_done", {31'd0, done}, 32'd0);

    // External master access while idle
    ext_write(8'd200, 32'hDEAD_BEEF);
    ext_read(8'd200, d);
    chk("ext_idle_rw", d, 32'hDEAD_BEEF);

    // Matrix 1..16, kernel {1,0,0,-1}: every output is -5
    for (int i = 0; i < 16; i++) mat_w[i] = 32'(i + 1);
    ker_w[0] = 32'd1; ker_w[1] = 32'd0; ker_w[2] = 32'd0; ker_w[3] = 32'hFFFF_FFFF;
    load(8'd0, 8'd16);
    run_conv("diag", 8'd0, 8'd16, 8'd20, 1'b0);
    ext_read(8'd24, d);
    chk("diag_const", d, 32'hFFFF_FFFB);

    // External master access while in DONE
    ext_write(8'd201, 32'h1234_5678);
    ext_read(8'd201, d);
    chk("ext_done_rw", d, 32'h1234_5678);

    // Kernel of ones
    for (int i = 0; i < 4; i++) ker_w[i] = 32'd1;
    load(8'd0, 8'd16);
    run_conv("ones", 8'd0, 8'd16, 8'd20, 1'b0);
    ext_read(8'd20, d);
    chk("ones_const", d, 32'd14);

    // Most negative operands: (-128*-128)*4 = 65536
    for (int i = 0; i < 16; i++) mat_w[i] = 32'h0000_0080;
    for (int i = 0; i < 4; i++) ker_w[i] = 32'hFFFF_FF80;
    load(8'd0, 8'd16);
    run_conv("neg", 8'd0, 8'd16, 8'd20, 1'b0);
    ext_read(8'd28, d);
    chk("neg_const", d, 32'd65536);

    // Reset in the middle of the matrix fetch
    for (int i = 0; i < 9; i++) ext_write(8'(60 + i), 32'hA5A5_0000 + 32'(i));
    for (int i = 0; i < 16; i++) mat_w[i] = $urandom;
    for (int i = 0; i < 4; i++) ker_w[i] = $urandom;
    load(8'd30, 8'd50);
    matrix_addr = 8'd30; kernel_addr = 8'd50; output_addr = 8'd60;
    pulse_start();
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_sel", {31'd0, dut_sel}, 32'd0);
    chk("midrst_w", {31'd0, dut_w}, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_hold_sel", {31'd0, dut_sel}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ext_read(8'(60 + i), d);
      chk($sformatf("midrst_keep%0d", i), d, 32'hA5A5_0000 + 32'(i));
    end
    run_conv("after_rst", 8'd30, 8'd50, 8'd60, 1'b0);

    // Matrix region wrapping past 255, with a start pulse while busy
    for (int i = 0; i < 16; i++) mat_w[i] = $urandom;
    for (int i = 0; i < 4; i++) ker_w[i] = $urandom;
    load(8'd250, 8'd100);
    run_conv("wrap", 8'd250, 8'd100, 8'd120, 1'b1);

    // Randomized runs at random (wrapping) bases
    for (int t = 0; t < 4; t++) begin
      base = 8'($urandom);
      for (int i = 0; i < 16; i++) mat_w[i] = $urandom;
      for (int i = 0; i < 4; i++) ker_w[i] = $urandom;
      load(base, base + 8'd16);
      run_conv($sformatf("rnd%0d", t), base, base + 8'd16, base + 8'd20, t[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
